// File: rtl/credit_tx_pkg.sv
// rtl/credit_tx_pkg.sv - shared types and helpers for the credit transmitter
package credit_tx_pkg;

  // Net operation applied to the credit counter in one cycle
  typedef enum logic [1:0] {
    CntHold = 2'd0,
    CntInc  = 2'd1,
    CntDec  = 2'd2
  } cnt_op_e;

  // Simultaneous return and consume cancel out, so only a lone event moves the count
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
    if (inc && !dec) begin
      return CntInc;
    end else if (dec && !inc) begin
      return CntDec;
    end
    return CntHold;
  endfunction

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - saturating up/down credit counter with overflow strobe
module credit_counter
  import credit_tx_pkg::*;
#(
  parameter int unsigned  NumCredits = 2,
  localparam int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                overflow_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  cnt_op_e             op;

  // Next count; a return while already full saturates and raises overflow for this cycle
  always_comb begin
    op         = cnt_op(inc_i, dec_i);
    cnt_d      = cnt_q;
    overflow_o = 1'b0;
    case (op)
      CntInc: begin
        if (cnt_q == MaxCnt) begin
          overflow_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      CntDec:  cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter register; reset grants the full receiver depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= MaxCnt;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == MaxCnt);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/credit_tx.sv
// rtl/credit_tx.sv - credit-based link transmitter with registered beat output
module credit_tx
  import credit_tx_pkg::*;
#(
  parameter type          T          = logic,
  parameter int unsigned  NumCredits = 2,
  localparam int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  T                    data_i,
  output logic                valid_o,
  output T                    data_o,
  input  logic                credit_i,
  output logic [CntWidth-1:0] credits_o,
  output logic                idle_o,
  output logic                err_o
);

  if (NumCredits < 1) begin : g_bad_credits
    $error("credit_tx: NumCredits must be at least 1");
  end

  logic acc;
  logic full, empty, overflow;
  logic valid_q, valid_d;
  T     data_q, data_d;
  logic err_q, err_d;

  credit_counter #(
    .NumCredits(NumCredits)
  ) u_credit_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc_i     (credit_i),
    .dec_i     (acc),
    .cnt_o     (credits_o),
    .full_o    (full),
    .empty_o   (empty),
    .overflow_o(overflow)
  );

  // ready comes only from the registered count, keeping link inputs off any output path
  assign ready_o = !empty;
  assign acc     = valid_i && ready_o;

  // Capture the beat on accept; data holds between beats, error is sticky until reset
  always_comb begin
    valid_d = acc;
    data_d  = data_q;
    err_d   = err_q || overflow;
    if (acc) begin
      data_d = data_i;
    end
  end

  // Output and error registers; reset drops any pending beat at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idle_o  = full;
  assign err_o   = err_q;

  // Upstream should hold its payload while stalled
  a_data_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_i && !ready_o) |=> (!valid_i || $stable(data_i)))
    else $warning("credit_tx: data_i changed while stalled");

endmodule

// File: tb/tb_credit_tx.sv
// tb/tb_credit_tx.sv - randomized self-checking bench for credit_tx
module tb_credit_tx;

  localparam int NC = 2;
  localparam int CW = $clog2(NC + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic [7:0]    data_i;
  logic          valid_o;
  logic [7:0]    data_o;
  logic          credit_i;
  logic [CW-1:0] credits_o;
  logic          idle_o;
  logic          err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural reference: credits as a plain integer, last beat, sticky error
  int         m_cred;
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_err;

  credit_tx #(
    .T         (logic [7:0]),
    .NumCredits(NC)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .credit_i (credit_i),
    .credits_o(credits_o),
    .idle_o   (idle_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred  = NC;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_err   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"},   valid_o,   m_valid);
    check({tag, ".data"},    data_o,    m_data);
    check({tag, ".credits"}, credits_o, m_cred);
    check({tag, ".idle"},    idle_o,    m_cred == NC);
    check({tag, ".err"},     err_o,     m_err);
  endtask

  // one clock cycle: drive, check ready before the edge, advance model, check after
  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic c);
    bit acc;
    valid_i  = v;
    data_i   = d;
    credit_i = c;
    check({tag, ".ready"}, ready_o, m_cred > 0);
    acc = v && (m_cred > 0);
    @(posedge clk_i);
    #1;
    if (c && !acc && m_cred == NC) m_err = 1'b1;
    m_cred = m_cred - int'(acc) + int'(c);
    if (m_cred > NC) m_cred = NC;
    m_valid = acc;
    if (acc) m_data = d;
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rv;
    bit         stalled;

    valid_i  = 1'b0;
    data_i   = 8'h00;
    credit_i = 1'b0;
    rst_ni   = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.ready", ready_o, 1'b1);
    check_outputs("rst");
    rst_ni = 1'b1;

    // credit exhaustion: A, B, C back to back with no returns
    step("ex0", 1'b1, 8'h0A, 1'b0);
    check("ex0.beatA", data_o, 8'h0A);
    step("ex1", 1'b1, 8'h0B, 1'b0);
    check("ex1.beatB", data_o, 8'h0B);
    check("ex1.empty", credits_o, 0);
    step("ex2", 1'b1, 8'h0C, 1'b0);
    check("ex2.held", valid_o, 1'b0);
    step("ex3", 1'b1, 8'h0C, 1'b0);
    step("ex4", 1'b1, 8'h0C, 1'b0);
    // credit return at cycle 5, C accepted at 6, emitted at 7
    step("cr5", 1'b1, 8'h0C, 1'b1);
    check("cr5.ready", ready_o, 1'b1);
    step("cr6", 1'b1, 8'h0C, 1'b0);
    check("cr6.beatC", data_o, 8'h0C);
    check("cr6.credits", credits_o, 0);

    // simultaneous accept and return at one credit
    step("sim0", 1'b0, 8'h00, 1'b1);
    step("sim1", 1'b1, 8'h5A, 1'b1);
    check("sim1.credits", credits_o, 1);
    check("sim1.pulse", valid_o, 1'b1);

    // overflow at full credit
    step("ov0", 1'b0, 8'h00, 1'b1);
    step("ov1", 1'b0, 8'h00, 1'b1);
    check("ov1.err", err_o, 1'b1);
    check("ov1.sat", credits_o, NC);
    step("ov2", 1'b1, 8'h11, 1'b0);
    step("ov3", 1'b0, 8'h00, 1'b1);
    check("ov3.sticky", err_o, 1'b1);

    // randomized traffic; payload held while a beat is stalled
    stalled = 1'b0;
    rd = 8'h00;
    rv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        rv = ($urandom_range(0, 3) != 0);
        rd = 8'($urandom);
      end
      stalled = rv && (m_cred == 0);
      step("rnd", rv, rd, ($urandom_range(0, 2) == 0));
      if (m_cred == 0 && rv && !m_valid) stalled = 1'b1;
      else if (m_valid) stalled = 1'b0;
    end

    // reset in the cycle after an accept
    step("mr0", 1'b0, 8'h00, 1'b1);
    step("mr1", 1'b1, 8'h77, 1'b0);
    valid_i  = 1'b0;
    credit_i = 1'b0;
    rst_ni   = 1'b0;
    #1;
    model_reset();
    check("mr.kill", valid_o, 1'b0);
    check("mr.credits", credits_o, NC);
    check_outputs("mr");
    @(posedge clk_i);
    #1;
    check_outputs("mr.hold");
    rst_ni = 1'b1;
    step("mr2", 1'b1, 8'h99, 1'b0);
    check("mr2.beat", data_o, 8'h99);
    step("mr3", 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/credit_tx.md
# credit_tx

Transmit end of a credit-based point-to-point link. It accepts beats on a valid/ready stream from upstream logic and forwards each beat as a one-cycle registered pulse. It sends only while it holds a credit, and the far-end receiver returns one credit per consumed beat. The block sits at the source side of long or retimed links whose sink is a fixed-depth buffer, such as a 2-entry spill-style register. No combinational path runs from any link-side input to any output.

## Interface
- T — default logic — beat payload type
- NumCredits — default 2 — receiver buffer depth; must be ≥1; sets the reset credit count
- CntWidth — localparam, $clog2(NumCredits+1) — counter width

- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- valid_i  input  1  upstream beat valid
- ready_o  output  1  upstream ready; high iff credits available
- data_i  input  T  upstream payload
- valid_o  output  1  link beat strobe, registered, one cycle per beat
- data_o  output  T  link payload, registered, valid while valid_o=1
- credit_i  input  1  one-cycle pulse from receiver; returns one credit
- credits_o  output  CntWidth  current credit count
- idle_o  output  1  high iff credits_o == NumCredits (all beats consumed)
- err_o  output  1  sticky credit-overflow flag

## Operation
- State: credit counter cnt_q, output registers valid_q/data_q, sticky err_q.
- Reset values: cnt_q=NumCredits, valid_o=0, data_o='0, err_o=0, so ready_o=1 and idle_o=1.
- ready_o = (cnt_q != 0). It depends only on registered state, never on valid_i or credit_i.
- Accept: acc = valid_i && ready_o. On acc, valid_q←1 and data_q←data_i. Otherwise valid_q←0 and data_q holds.
- Credit return: ret = credit_i.
- Counter update:
  - acc only: cnt−1.
  - ret only: cnt+1.
  - acc and ret together: unchanged.
- Overflow: ret && !acc && cnt_q==NumCredits. The counter saturates (stays NumCredits) and err_q←1. err_q clears only on reset.
- Underflow is impossible by construction, since acc requires cnt_q≠0.
- Upstream valid_i may be dropped or data_i changed while ready_o=0. No beat is lost or duplicated.
- Counter arithmetic is unsigned CntWidth. The counter never wraps.

## Timing
- Forward latency is 1 cycle: acc at cycle t gives valid_o=1 and data_o=beat at t+1.
- Throughput is one beat per cycle while credits last. Sustained full rate needs round-trip latency ≤ NumCredits cycles.
- A credit at cycle t affects ready_o at t+1. With cnt_q=0 and credit_i at t, ready_o rises at t+1 and the earliest new valid_o is at t+2.
- The last credit consumed at t drops ready_o at t+1.
- Asynchronous reset mid-transfer clears the counter to NumCredits and kills any pending valid_o pulse immediately. In-flight credits from the link are the system's responsibility: reset both ends together.

## Structure
- No shared package typedefs are required. CntWidth stays a local param.
- One natural sub-module is credit_counter: up/down counter with saturation and overflow flag, parameterised by NumCredits, with ports inc_i, dec_i, cnt_o, full_o, empty_o, overflow_o.
- The top level holds the output register and handshake logic.
- Assertions:
  - NumCredits ≥ 1 (elaboration).
  - data_i stable while valid_i && !ready_o (warning only).

## Test plan
- **Reset:** NumCredits=2, hold rst_ni=0 → ready_o=1, valid_o=0, data_o=0, credits_o=2, idle_o=1, err_o=0.
- **Credit exhaustion:** drive beats 0xA, 0xB, 0xC back-to-back from cycle 0 with no credit_i.
  - valid_o=1 with data_o=0xA at cycle 1 and 0xB at cycle 2.
  - ready_o=0 from cycle 2; credits_o=0.
  - 0xC is held with no valid_o.
- **Credit return:** continuing the previous case, pulse credit_i at cycle 5.
  - ready_o=1 at cycle 6 and 0xC is accepted.
  - valid_o with 0xC at cycle 7; credits_o=0 at cycle 7.
- **Simultaneous accept and return:** credits_o=1, valid_i=1 and credit_i=1 in the same cycle → credits_o stays 1, ready_o stays 1, valid_o pulses next cycle.
- **Overflow:** credits_o=2, pulse credit_i → credits_o stays 2 and err_o=1 next cycle. err_o remains 1 through later traffic until rst_ni asserts.
- **Reset mid-operation:** assert rst_ni low in the cycle after an accept → valid_o=0 immediately and credits_o=2 while in reset. After release, the first beat appears one cycle after its accept.
